// File: rtl/ecg_sample_writer_pkg.sv
// ----------------------------------------------------------------------------
// ecg_sample_writer_pkg
// Shared definitions for the ECG trace-RAM writer:
//   - default widths for the ADC sample, the RAM address and the RAM word
//   - decimation counter / exponent widths
//   - writer FSM state encoding (IDLE=0, FILL=1, WRAP=2, HOLD=3)
//   - window_last(): index of the last sample in a 2^k window
// ----------------------------------------------------------------------------
package ecg_sample_writer_pkg;

    localparam int ADC_W_DEF   = 12;
    localparam int ADDR_W_DEF  = 10;
    localparam int DATA_W_DEF  = 10;
    localparam int K_W         = 3;   // decimation exponent width, k = 0..7
    localparam int DECIM_CNT_W = 7;   // counts up to 2^7 - 1

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_WRAP = 2'd2,
        ST_HOLD = 2'd3
    } wr_state_t;

    // Last counter value of a window of 2^k samples.
    function automatic logic [DECIM_CNT_W-1:0] window_last(input logic [K_W-1:0] k);
        logic [7:0] span;
        span = 8'd1 << k;
        return DECIM_CNT_W'(span - 8'd1);
    endfunction

endpackage

// File: rtl/ecg_sample_writer_if.sv
// ----------------------------------------------------------------------------
// ecg_sample_writer_if
// RAM write-side bus of the ECG trace buffer plus the status the display
// reader needs to align its scan.
//   we          1       RAM write enable, one-cycle pulse
//   addr_in     ADDR_W  RAM write address
//   din         DATA_W  RAM write data
//   wr_ptr      ADDR_W  address of most recent completed write
//   full        1       buffer has wrapped at least once since leaving IDLE
//   frame_done  1       one-cycle pulse on the write to the last address
// Modports: master (writer drives), slave (RAM / display reader observes).
// ----------------------------------------------------------------------------
interface ecg_sample_writer_if
    import ecg_sample_writer_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              we;
    logic [ADDR_W-1:0] addr_in;
    logic [DATA_W-1:0] din;
    logic [ADDR_W-1:0] wr_ptr;
    logic              full;
    logic              frame_done;

    modport master (output we, addr_in, din, wr_ptr, full, frame_done);
    modport slave  (input  we, addr_in, din, wr_ptr, full, frame_done);
endinterface

// File: rtl/ecg_sample_writer_decimator.sv
// ----------------------------------------------------------------------------
// ecg_sample_writer_decimator
// Groups accepted ADC samples into windows of 2^k and flags the sample that
// closes each window. k is taken from decim_log2 on the first sample of a
// window and held for the rest of it.
// Build option: ECG_AVG_EN defined -> win_data is the window mean (sum >> k);
//               otherwise win_data is the closing sample (pure decimation).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   clear          drops any partial window (and the accumulator)
//   sample_valid   sample strobe; ignored while clear is high
//   decim_log2     decimation exponent k
//   sample_data    unsigned ADC code
//   win_done       combinational: this sample closes a window
//   win_data       top DATA_W bits of the window result
// ----------------------------------------------------------------------------
module ecg_sample_writer_decimator
    import ecg_sample_writer_pkg::*;
#(
    parameter int ADC_W  = ADC_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              sample_valid,
    input  logic [K_W-1:0]    decim_log2,
    input  logic [ADC_W-1:0]  sample_data,
    output logic              win_done,
    output logic [DATA_W-1:0] win_data
);

    logic [DECIM_CNT_W-1:0] cnt_reg;
    logic [K_W-1:0]         k_reg;
    logic [K_W-1:0]         k_eff;
    logic                   accept;
    logic [ADC_W-1:0]       mean;
    logic                   unused_mean_bits;

    assign accept   = sample_valid && !clear;
    // On the first sample of a window the live exponent applies; afterwards
    // the latched one, so mid-window changes only affect the next window.
    assign k_eff    = (cnt_reg == '0) ? decim_log2 : k_reg;
    assign win_done = accept && (cnt_reg == window_last(k_eff));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
            k_reg   <= '0;
        end else if (clear) begin
            cnt_reg <= '0;
        end else if (accept) begin
            if (cnt_reg == '0) begin
                k_reg <= decim_log2;
            end
            cnt_reg <= win_done ? '0 : cnt_reg + DECIM_CNT_W'(1);
        end
    end

`ifdef ECG_AVG_EN
    localparam int SUM_W = ADC_W + 7;

    logic [SUM_W-1:0] acc_reg;
    logic [SUM_W-1:0] sum_next;

    // The first sample of a window starts a fresh sum.
    assign sum_next = ((cnt_reg == '0) ? '0 : acc_reg) + SUM_W'(sample_data);
    assign mean     = ADC_W'(sum_next >> k_eff);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
        end else if (clear) begin
            acc_reg <= '0;
        end else if (accept) begin
            acc_reg <= win_done ? '0 : sum_next;
        end
    end
`else
    assign mean = sample_data;
`endif

    // Truncate to the RAM word: keep the MSBs, drop the LSBs without rounding.
    assign win_data         = mean[ADC_W-1 -: DATA_W];
    assign unused_mean_bits = ^mean;

endmodule

// File: rtl/ecg_sample_writer.sv
// ----------------------------------------------------------------------------
// ecg_sample_writer
// Upstream feeder of the ECG trace RAM. Accepts ADC samples, decimates by
// 2^k, scales to the RAM word and writes into a 2**ADDR_W circular buffer.
// Publishes the last written address and wrap status; freeze holds the
// buffer contents for a still display.
// Build option: ECG_AVG_EN (window averaging instead of pure decimation).
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   en            capture enable; low forces IDLE and clears address/full
//   freeze        level; high suspends writes (pointers held)
//   decim_log2    decimation exponent k (0..7), applied at window start
//   sample_valid  one-cycle strobe qualifying sample_data
//   sample_data   unsigned ADC code
//   wr            RAM write bus / status (ecg_sample_writer_if.master)
// ----------------------------------------------------------------------------
module ecg_sample_writer
    import ecg_sample_writer_pkg::*;
#(
    parameter int ADC_W  = ADC_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             freeze,
    input  logic [K_W-1:0]   decim_log2,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] sample_data,
    ecg_sample_writer_if.master wr
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    wr_state_t         state_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] addr_reg;       // address of the current/last write
    logic [ADDR_W-1:0] addr_next_reg;  // address the next write will use
    logic [DATA_W-1:0] din_reg;
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic              full_reg;
    logic              frame_done_reg;

    logic              capturing;
    logic              win_done;
    logic [DATA_W-1:0] win_data;

    // Samples only count while actively filling; anything else discards the
    // partial window.
    assign capturing = en && !freeze && (state_reg == ST_FILL || state_reg == ST_WRAP);

    ecg_sample_writer_decimator #(
        .ADC_W  (ADC_W),
        .DATA_W (DATA_W)
    ) u_decim (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (!capturing),
        .sample_valid (sample_valid),
        .decim_log2   (decim_log2),
        .sample_data  (sample_data),
        .win_done     (win_done),
        .win_data     (win_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            we_reg         <= 1'b0;
            addr_reg       <= '0;
            addr_next_reg  <= '0;
            din_reg        <= '0;
            wr_ptr_reg     <= '0;
            full_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            we_reg         <= 1'b0;
            frame_done_reg <= 1'b0;
            // wr_ptr follows once the write cycle has completed.
            if (we_reg) begin
                wr_ptr_reg <= addr_reg;
            end
            if (!en) begin
                state_reg     <= ST_IDLE;
                addr_reg      <= '0;
                addr_next_reg <= '0;
                full_reg      <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: state_reg <= ST_FILL;
                    ST_FILL, ST_WRAP: begin
                        if (freeze) begin
                            state_reg <= ST_HOLD;
                        end else if (win_done) begin
                            we_reg        <= 1'b1;
                            addr_reg      <= addr_next_reg;
                            din_reg       <= win_data;
                            addr_next_reg <= addr_next_reg + ADDR_W'(1);
                            if (addr_next_reg == LAST_ADDR) begin
                                frame_done_reg <= 1'b1;
                                full_reg       <= 1'b1;
                                state_reg      <= ST_WRAP;
                            end
                        end
                    end
                    ST_HOLD: begin
                        if (!freeze) begin
                            state_reg <= full_reg ? ST_WRAP : ST_FILL;
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign wr.we         = we_reg;
    assign wr.addr_in    = addr_reg;
    assign wr.din        = din_reg;
    assign wr.wr_ptr     = wr_ptr_reg;
    assign wr.full       = full_reg;
    assign wr.frame_done = frame_done_reg;

endmodule

// File: tb/tb_ecg_sample_writer.sv
// ----------------------------------------------------------------------------
// tb_ecg_sample_writer
// Scoreboard bench for ecg_sample_writer: expected RAM writes are queued as
// samples are driven and compared when the writer pulses we. One line is
// printed per RAM write. Honours ECG_AVG_EN for the averaged-data cases.
// ----------------------------------------------------------------------------
module tb_ecg_sample_writer;

    localparam int ADC_W  = 12;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 10;

    logic             clk          = 1'b0;
    logic             rst_n        = 1'b1;
    logic             en           = 1'b0;
    logic             freeze       = 1'b0;
    logic [2:0]       decim_log2   = 3'd0;
    logic             sample_valid = 1'b0;
    logic [ADC_W-1:0] sample_data  = '0;

    ecg_sample_writer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) wr_if ();

    ecg_sample_writer #(
        .ADC_W  (ADC_W),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .freeze       (freeze),
        .decim_log2   (decim_log2),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .wr           (wr_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] din;
    } wr_exp_t;

    wr_exp_t sb_q[$];
    int      chk_cnt  = 0;
    int      pass_cnt = 0;
    int      exp_addr = 0;

    task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
        chk_cnt++;
        if (got == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [DATA_W-1:0] to_din(input logic [ADC_W-1:0] s);
        return s[ADC_W-1 -: DATA_W];
    endfunction

    // Queue a write of word d at the model's next address.
    task automatic expect_word(input logic [DATA_W-1:0] d);
        wr_exp_t e;
        e.addr = exp_addr[ADDR_W-1:0];
        e.din  = d;
        sb_q.push_back(e);
        exp_addr = (exp_addr + 1) % (1 << ADDR_W);
    endtask

    // All stimulus tasks start and end at posedge + 1.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [ADC_W-1:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
    endtask

    task automatic send_k0(input logic [ADC_W-1:0] d);
        expect_word(to_din(d));
        send(d);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_we"},         wr_if.we,         0);
        check_val({tag, "_addr_in"},    wr_if.addr_in,    0);
        check_val({tag, "_din"},        wr_if.din,        0);
        check_val({tag, "_wr_ptr"},     wr_if.wr_ptr,     0);
        check_val({tag, "_full"},       wr_if.full,       0);
        check_val({tag, "_frame_done"}, wr_if.frame_done, 0);
    endtask

    // Write monitor / scoreboard compare.
    always @(negedge clk) begin : monitor
        wr_exp_t e;
        if (wr_if.we) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_we", 1, 0);
            end else begin
                e = sb_q.pop_front();
                $display("write addr=%0d din=0x%03h frame_done=%0d", wr_if.addr_in, wr_if.din, wr_if.frame_done);
                check_val("addr_in", wr_if.addr_in, e.addr);
                check_val("din", wr_if.din, e.din);
                check_val("frame_done", wr_if.frame_done, (e.addr == {ADDR_W{1'b1}}) ? 1 : 0);
            end
        end else if (wr_if.frame_done) begin
            check_val("frame_done_without_we", 1, 0);
        end
    end

    initial begin
        logic [ADC_W-1:0] w1_src;
        logic [ADC_W-1:0] w2_src;
        logic [ADC_W-1:0] t6_src;

        // Power-on reset
        #2 rst_n = 1'b0;
        #1 check_all_zero("por");
        idle(2);
        rst_n = 1'b1;
        idle(1);

        // k=0 straight pass-through
        en = 1'b1;
        decim_log2 = 3'd0;
        idle(1);
        send_k0(12'hFFF);
        send_k0(12'h800);
        send_k0(12'h004);

        // k=2, two windows; k changed mid-second-window must not apply yet
`ifdef ECG_AVG_EN
        w1_src = 12'h101;
        w2_src = 12'h105;
`else
        w1_src = 12'h103;
        w2_src = 12'h107;
`endif
        expect_word(to_din(w1_src));
        expect_word(to_din(w2_src));
        decim_log2 = 3'd2;
        for (int i = 0; i < 8; i++) begin
            if (i == 5) decim_log2 = 3'd0;
            send(12'(12'h100 + i));
        end
        idle(3);

        // Run up to addr 37, then assert reset mid-cycle
        for (int i = 0; i < 33; i++) send_k0(12'(i * 16 + 7));
        idle(3);
        check_val("pre_reset_addr_in", wr_if.addr_in, 37);
        check_val("pre_reset_wr_ptr",  wr_if.wr_ptr,  37);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1 check_all_zero("async_reset");
        exp_addr = 0;
        idle(1);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) send(12'hABC);   // ignored: en low
        idle(2);
        check_val("idle_addr_in", wr_if.addr_in, 0);

        // k=3 partial window discarded by en drop
`ifdef ECG_AVG_EN
        t6_src = 12'h048;
`else
        t6_src = 12'h080;
`endif
        en = 1'b1;
        decim_log2 = 3'd3;
        idle(1);
        for (int i = 0; i < 5; i++) send(12'hFFF);
        en = 1'b0;
        exp_addr = 0;
        idle(2);
        en = 1'b1;
        idle(1);
        expect_word(to_din(t6_src));
        for (int i = 0; i < 8; i++) send(12'((i + 1) * 16));
        idle(3);
        check_val("endrop_wr_ptr", wr_if.wr_ptr, 0);

        // Freeze after 10 writes; first frozen sample coincides with freeze
        en = 1'b0;
        exp_addr = 0;
        idle(1);
        en = 1'b1;
        decim_log2 = 3'd0;
        idle(1);
        for (int i = 0; i < 10; i++) send_k0(12'(i * 37 + 100));
        freeze = 1'b1;
        for (int i = 0; i < 20; i++) send(12'(i * 11));
        idle(2);
        check_val("freeze_wr_ptr",  wr_if.wr_ptr,  9);
        check_val("freeze_addr_in", wr_if.addr_in, 9);
        freeze = 1'b0;
        idle(1);
        send_k0(12'h5A5);
        idle(3);
        check_val("unfreeze_wr_ptr", wr_if.wr_ptr, 10);

        // Wrap: 1030 writes from address 0
        en = 1'b0;
        exp_addr = 0;
        idle(1);
        en = 1'b1;
        idle(1);
        for (int i = 0; i < 1030; i++) begin
            send_k0(12'($urandom_range(0, 4095)));
            if (i == 1022) check_val("full_before_wrap", wr_if.full, 0);
            if (i == 1023) check_val("full_at_wrap",     wr_if.full, 1);
        end
        idle(3);
        check_val("wrap_wr_ptr",  wr_if.wr_ptr,  5);
        check_val("wrap_addr_in", wr_if.addr_in, 5);
        check_val("wrap_full",    wr_if.full,    1);
        en = 1'b0;
        idle(1);
        check_val("idle_full_clear", wr_if.full,    0);
        check_val("idle_addr_clear", wr_if.addr_in, 0);

        idle(2);
        check_val("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
